// File: rtl/cc_pkg.sv
// Shared definitions for the condition-code register and branch-condition decoder:
// flag width, flag bit positions within {N,Z,V,C}, and the 4-bit condition encoding.
package cc_pkg;

    localparam int CC_W   = 4;
    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    typedef enum logic [3:0] {
        EQ = 4'd0,
        NE = 4'd1,
        CS = 4'd2,
        CC = 4'd3,
        MI = 4'd4,
        PL = 4'd5,
        VS = 4'd6,
        VC = 4'd7,
        HI = 4'd8,
        LS = 4'd9,
        GE = 4'd10,
        LT = 4'd11,
        GT = 4'd12,
        LE = 4'd13,
        AL = 4'd14,
        NV = 4'd15
    } cond_e;

endpackage

// File: rtl/cc_cond_eval.sv
// Purely combinational branch-condition decoder: maps a 4-bit condition select and
// the registered {N,Z,V,C} flags to a single taken/not-taken result.
module cc_cond_eval
    import cc_pkg::*;
(
    input  logic [CC_W-1:0] cc,
    input  logic [3:0]      cond,
    output logic            cond_true
);

    logic n, z, v, c;

    assign n = cc[FLAG_N];
    assign z = cc[FLAG_Z];
    assign v = cc[FLAG_V];
    assign c = cc[FLAG_C];

    // C set means "no borrow" after a subtract, so HI/LS are the unsigned compares.
    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond))
            EQ: cond_true = z;
            NE: cond_true = ~z;
            CS: cond_true = c;
            CC: cond_true = ~c;
            MI: cond_true = n;
            PL: cond_true = ~n;
            VS: cond_true = v;
            VC: cond_true = ~v;
            HI: cond_true = c & ~z;
            LS: cond_true = ~c | z;
            GE: cond_true = (n == v);
            LT: cond_true = (n != v);
            GT: cond_true = ~z & (n == v);
            LE: cond_true = z | (n != v);
            AL: cond_true = 1'b1;
            NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_code_reg.sv
// Condition-code register with branch-condition output and optional LIFO shadow stack
// for interrupt entry/exit. The stack is built only when CC_SHADOW_STACK_EN is defined.
module cond_code_reg
    import cc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_z,
    input  logic            alu_v,
    input  logic            alu_c,
    input  logic            alu_n,
    input  logic            cc_we,
    input  logic [CC_W-1:0] cc_mask,
    input  logic            cc_wr,
    input  logic [CC_W-1:0] cc_wdata,
    input  logic            push,
    input  logic            pop,
    input  logic [3:0]      cond,
    output logic [CC_W-1:0] cc,
    output logic            pre_c,
    output logic            cond_true,
    output logic            stk_full,
    output logic            stk_empty,
    output logic            stk_err
);

    logic [CC_W-1:0] cc_q, cc_d;
    logic [CC_W-1:0] alu_flags;
    logic [CC_W-1:0] write_val;

    assign alu_flags = {alu_n, alu_z, alu_v, alu_c};

    // Value the register takes when no stack restore happens this cycle.
    always_comb begin
        write_val = cc_q;
        if (cc_wr) begin
            write_val = cc_wdata;
        end else if (cc_we) begin
            write_val = (cc_q & ~cc_mask) | (alu_flags & cc_mask);
        end
    end

`ifdef CC_SHADOW_STACK_EN
    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH);

    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_dec;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             err_q, err_d;
    logic [CC_W-1:0]  stack_q [DEPTH];
    logic [CC_W-1:0]  stack_d [DEPTH];
    logic             push_ok, pop_ok;

    assign ptr_dec = ptr_q - PTR_W'(1);

    // A simultaneous push and pop is treated as a conflict: neither takes effect.
    always_comb begin
        push_ok = push & ~pop & ~full_q;
        pop_ok  = pop & ~push & ~empty_q;
        cc_d    = write_val;
        ptr_d   = ptr_q;
        stack_d = stack_q;
        err_d   = err_q;
        if (push_ok) begin
            stack_d[ptr_q[IDX_W-1:0]] = cc_q;
            ptr_d                     = ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            cc_d  = stack_q[ptr_dec[IDX_W-1:0]];
            ptr_d = ptr_dec;
        end
        if ((push & pop) | (push & full_q) | (pop & empty_q)) begin
            err_d = 1'b1;
        end
        full_d  = (ptr_d == PTR_MAX);
        empty_d = (ptr_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    // Stack contents are don't-care after reset, so the storage has no reset.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign stk_full  = full_q;
    assign stk_empty = empty_q;
    assign stk_err   = err_q;
`else
    logic unused_stack_in;

    assign unused_stack_in = push ^ pop;
    assign cc_d            = write_val;
    assign stk_full        = 1'b0;
    assign stk_empty       = 1'b1;
    assign stk_err         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= '0;
        end else begin
            cc_q <= cc_d;
        end
    end

    assign cc    = cc_q;
    assign pre_c = cc_q[FLAG_C];

    cc_cond_eval u_cond_eval (
        .cc        (cc_q),
        .cond      (cond),
        .cond_true (cond_true)
    );

endmodule

// File: tb/tb_cond_code_reg.sv
// Self-checking bench for cond_code_reg: table-driven register/condition vectors plus
// hand-written shadow-stack and reset sequences (stack expectations follow CC_SHADOW_STACK_EN).
module tb_cond_code_reg;
    import cc_pkg::*;

`ifdef CC_SHADOW_STACK_EN
    localparam bit STK_EN = 1'b1;
`else
    localparam bit STK_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       alu_z, alu_v, alu_c, alu_n;
    logic       cc_we;
    logic [3:0] cc_mask;
    logic       cc_wr;
    logic [3:0] cc_wdata;
    logic       push, pop;
    logic [3:0] cond;
    logic [3:0] cc;
    logic       pre_c;
    logic       cond_true;
    logic       stk_full, stk_empty, stk_err;

    int n_checks = 0;
    int n_fail   = 0;

    cond_code_reg #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_z     (alu_z),
        .alu_v     (alu_v),
        .alu_c     (alu_c),
        .alu_n     (alu_n),
        .cc_we     (cc_we),
        .cc_mask   (cc_mask),
        .cc_wr     (cc_wr),
        .cc_wdata  (cc_wdata),
        .push      (push),
        .pop       (pop),
        .cond      (cond),
        .cc        (cc),
        .pre_c     (pre_c),
        .cond_true (cond_true),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .stk_err   (stk_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        string      name;
        logic       we;
        logic [3:0] mask;
        logic       wr;
        logic [3:0] wdata;
        logic [3:0] alu;    // {N,Z,V,C}
        logic [3:0] cnd;
        logic [3:0] exp_cc;
        logic       exp_ct;
    } vec_t;

    vec_t vecs [20];

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        cc_we    = v.we;
        cc_mask  = v.mask;
        cc_wr    = v.wr;
        cc_wdata = v.wdata;
        {alu_n, alu_z, alu_v, alu_c} = v.alu;
        cond     = v.cnd;
        push     = 1'b0;
        pop      = 1'b0;
    endtask

    task automatic idleInputs();
        cc_we    = 1'b0;
        cc_mask  = 4'h0;
        cc_wr    = 1'b0;
        cc_wdata = 4'h0;
        push     = 1'b0;
        pop      = 1'b0;
        {alu_n, alu_z, alu_v, alu_c} = 4'h0;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;

        //             name          we   mask   wr   wdata  alu    cond      cc     ct
        vecs[0]  = '{"add_eq",       1'b1, 4'hF, 1'b0, 4'h0, 4'b0000, EQ, 4'b0000, 1'b0};
        vecs[1]  = '{"add_pl",       1'b0, 4'h0, 1'b0, 4'h0, 4'b0000, PL, 4'b0000, 1'b1};
        vecs[2]  = '{"sub_lt",       1'b1, 4'hF, 1'b0, 4'h0, 4'b1000, LT, 4'b1000, 1'b1};
        vecs[3]  = '{"sub_cc",       1'b0, 4'h0, 1'b0, 4'h0, 4'b0000, CC, 4'b1000, 1'b1};
        vecs[4]  = '{"sub_hi",       1'b0, 4'h0, 1'b0, 4'h0, 4'b0000, HI, 4'b1000, 1'b0};
        vecs[5]  = '{"c_only_cs",    1'b1, 4'h1, 1'b0, 4'h0, 4'b0011, CS, 4'b1001, 1'b1};
        vecs[6]  = '{"c_ge",         1'b0, 4'h0, 1'b0, 4'h0, 4'b0000, GE, 4'b1001, 1'b0};
        vecs[7]  = '{"c_gt",         1'b0, 4'h0, 1'b0, 4'h0, 4'b0000, GT, 4'b1001, 1'b0};
        vecs[8]  = '{"c_le",         1'b0, 4'h0, 1'b0, 4'h0, 4'b0000, LE, 4'b1001, 1'b1};
        vecs[9]  = '{"c_hi",         1'b0, 4'h0, 1'b0, 4'h0, 4'b0000, HI, 4'b1001, 1'b1};
        vecs[10] = '{"c_ls",         1'b0, 4'h0, 1'b0, 4'h0, 4'b0000, LS, 4'b1001, 1'b0};
        vecs[11] = '{"c_al",         1'b0, 4'h0, 1'b0, 4'h0, 4'b0000, AL, 4'b1001, 1'b1};
        vecs[12] = '{"c_nv",         1'b0, 4'h0, 1'b0, 4'h0, 4'b0000, NV, 4'b1001, 1'b0};
        vecs[13] = '{"c_mi",         1'b0, 4'h0, 1'b0, 4'h0, 4'b0000, MI, 4'b1001, 1'b1};
        vecs[14] = '{"c_vs",         1'b0, 4'h0, 1'b0, 4'h0, 4'b0000, VS, 4'b1001, 1'b0};
        vecs[15] = '{"c_ne",         1'b0, 4'h0, 1'b0, 4'h0, 4'b0000, NE, 4'b1001, 1'b1};
        vecs[16] = '{"wr_over_we",   1'b1, 4'hF, 1'b1, 4'h4, 4'b1111, EQ, 4'b0100, 1'b1};
        vecs[17] = '{"zv_mask_vs",   1'b1, 4'h6, 1'b0, 4'h0, 4'b0010, VS, 4'b0010, 1'b1};
        vecs[18] = '{"no_mask_vc",   1'b1, 4'h0, 1'b0, 4'h0, 4'b1111, VC, 4'b0010, 1'b0};
        vecs[19] = '{"wr_ge",        1'b0, 4'h0, 1'b1, 4'h9, 4'b0000, GE, 4'b1001, 1'b0};

        rst_n = 1'b0;
        cond  = 4'd0;
        idleInputs();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_cc",    cc,        4'b0000);
        checkOutput("rst_pre_c", pre_c,     1'b0);
        checkOutput("rst_full",  stk_full,  1'b0);
        checkOutput("rst_empty", stk_empty, 1'b1);
        checkOutput("rst_err",   stk_err,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Register path and condition decode
        for (int i = 0; i < 20; i++) begin
            v = vecs[i];
            applyStimulus(v);
            stepEdge();
            checkOutput({v.name, "_cc"},    cc,        v.exp_cc);
            checkOutput({v.name, "_pre_c"}, pre_c,     v.exp_cc[0]);
            checkOutput({v.name, "_cond"},  cond_true, v.exp_ct);
        end

        // Save, overwrite, restore
        @(negedge clk); idleInputs(); push = 1'b1;
        stepEdge();
        checkOutput("sa_push_cc",    cc,        4'b1001);
        checkOutput("sa_push_empty", stk_empty, STK_EN ? 1'b0 : 1'b1);
        @(negedge clk); idleInputs(); cc_wr = 1'b1; cc_wdata = 4'b0100;
        stepEdge();
        checkOutput("sa_wr_cc",      cc,        4'b0100);
        @(negedge clk); idleInputs(); pop = 1'b1;
        stepEdge();
        checkOutput("sa_pop_cc",     cc,        STK_EN ? 4'b1001 : 4'b0100);
        checkOutput("sa_pop_empty",  stk_empty, 1'b1);
        checkOutput("sa_pop_err",    stk_err,   1'b0);

        // Fill past capacity while rewriting cc each cycle, then drain past empty
        @(negedge clk); idleInputs(); cc_wr = 1'b1; cc_wdata = 4'b0001;
        stepEdge();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk); idleInputs(); push = 1'b1; cc_wr = 1'b1; cc_wdata = 4'(i + 1);
            stepEdge();
            checkOutput($sformatf("fill%0d_cc", i),   cc,       4'(i + 1));
            checkOutput($sformatf("fill%0d_full", i), stk_full, (STK_EN && i >= 4) ? 1'b1 : 1'b0);
            checkOutput($sformatf("fill%0d_err", i),  stk_err,  (STK_EN && i >= 5) ? 1'b1 : 1'b0);
        end
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk); idleInputs(); pop = 1'b1;
            stepEdge();
            checkOutput($sformatf("drain%0d_cc", j),    cc,        STK_EN ? 4'(5 - j) : 4'b0110);
            checkOutput($sformatf("drain%0d_full", j),  stk_full,  1'b0);
            checkOutput($sformatf("drain%0d_empty", j), stk_empty, (!STK_EN || j == 4) ? 1'b1 : 1'b0);
        end
        @(negedge clk); idleInputs(); pop = 1'b1;
        stepEdge();
        checkOutput("under_cc",    cc,        STK_EN ? 4'b0001 : 4'b0110);
        checkOutput("under_empty", stk_empty, 1'b1);
        @(negedge clk); idleInputs(); pop = 1'b1; cc_wr = 1'b1; cc_wdata = 4'b1010;
        stepEdge();
        checkOutput("under_wr_cc", cc,        4'b1010);
        checkOutput("under_err",   stk_err,   STK_EN ? 1'b1 : 1'b0);
        @(negedge clk); idleInputs(); push = 1'b1; pop = 1'b1;
        stepEdge();
        checkOutput("pp_cc",    cc,        4'b1010);
        checkOutput("pp_empty", stk_empty, 1'b1);
        checkOutput("pp_full",  stk_full,  1'b0);

        // Reset mid-operation with a full write presented
        @(negedge clk); idleInputs();
        cc_we = 1'b1; cc_mask = 4'hF; {alu_n, alu_z, alu_v, alu_c} = 4'b1111;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_cc_now",  cc,      4'b0000);
        checkOutput("arst_err_now", stk_err, 1'b0);
        stepEdge();
        checkOutput("arst_cc_edge", cc,      4'b0000);
        @(negedge clk); idleInputs(); rst_n = 1'b1;
        stepEdge();
        checkOutput("post_rst_cc",    cc,        4'b0000);
        checkOutput("post_rst_pre_c", pre_c,     1'b0);
        checkOutput("post_rst_empty", stk_empty, 1'b1);
        stepEdge();
        checkOutput("post_rst_hold",  cc,        4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
